// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a small register bank. Every SPI input is
// resynchronised into clk; frames are R/W bit, address, data, MSB first.
module spi_reg_bank #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int HDR_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int FLUSH_W   = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]  CNT_HDR   = CNT_W'(HDR_LEN);
  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NREGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_OVER = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]           r_sclk_sync;
  logic [SYNC_STAGES-1:0]           r_ncs_sync;
  logic [SYNC_STAGES-1:0]           r_copi_sync;
  logic                             r_sclk_d;
  logic                             r_ncs_d;
  logic [FLUSH_W-1:0]               r_flush;
  logic                             r_armed;
  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [CNT_W-1:0]                 r_cnt;
  logic [FRAME_LEN-1:0]             r_shift;
  logic                             r_rw;
  logic [DATA_W-1:0]                r_shadow;
  logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
  logic [NUM_REGS-1:0]              r_strobe;
  logic                             r_err;
  logic                             r_cipo;
  logic                             r_oe;

  logic                             w_sclk;
  logic                             w_ncs;
  logic                             w_copi;
  logic                             w_sclk_rise;
  logic                             w_sclk_fall;
  logic                             w_ncs_rise;
  logic                             w_ncs_fall;
  logic [CNT_W-1:0]                 w_cnt_inc;
  logic [HDR_LEN-1:0]               w_hdr;
  logic [DATA_W-1:0]                w_rd_data;
  logic                             w_enter_data;
  logic                             w_frame_rw;
  logic [ADDR_W-1:0]                w_frame_addr;
  logic [DATA_W-1:0]                w_frame_data;
  logic                             w_addr_ok;
  logic                             w_frame_end;
  logic                             w_commit;
  logic                             w_reject;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ncs_rise  = w_ncs & ~r_ncs_d;
  assign w_ncs_fall  = ~w_ncs & r_ncs_d;

  assign w_cnt_inc    = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_hdr        = {r_shift[ADDR_W-1:0], w_copi};
  assign w_enter_data = (r_state == S_ADDR) && (w_state_nxt == S_DATA);

  assign w_frame_rw   = r_shift[FRAME_LEN-1];
  assign w_frame_addr = r_shift[FRAME_LEN-2 -: ADDR_W];
  assign w_frame_data = r_shift[DATA_W-1:0];
  assign w_addr_ok    = ({1'b0, w_frame_addr} < NREGS_EXT);
  assign w_frame_end  = w_ncs_rise && (r_state != S_IDLE);

  // Input synchronisers and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_sclk_d    <= w_sclk;
      r_ncs_d     <= w_ncs;
    end
  end

  // Synchroniser output is only trusted once the reset preset has flushed;
  // a frame already in flight at reset release is then skipped until ncs is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush <= FLUSH_W'(SYNC_STAGES);
      r_armed <= 1'b0;
    end else begin
      if (r_flush != '0) begin
        r_flush <= r_flush - FLUSH_W'(1);
      end
      if ((r_flush == '0) && w_ncs) begin
        r_armed <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_ncs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_armed && w_ncs_fall) w_state_nxt = S_ADDR;
          else                       w_state_nxt = S_IDLE;
        end
        S_ADDR: begin
          if (w_sclk_rise && (w_cnt_inc == CNT_HDR)) w_state_nxt = S_DATA;
          else                                       w_state_nxt = S_ADDR;
        end
        S_DATA: begin
          if (w_sclk_rise && (w_cnt_inc == CNT_FRAME)) w_state_nxt = S_OVER;
          else                                         w_state_nxt = S_DATA;
        end
        S_OVER:  w_state_nxt = S_OVER;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Read mux for the shadow load; unimplemented addresses read as zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd_data = (w_hdr[ADDR_W-1:0] == ADDR_W'(i)) ? r_regs[i] : w_rd_data;
    end
  end

  // Frame-end decision: commit a well-formed write, flag anything malformed
  always_comb begin
    w_commit = 1'b0;
    w_reject = 1'b0;
    if (w_frame_end) begin
      if (r_cnt == '0) begin
        w_reject = 1'b0;
      end else if (r_cnt != CNT_FRAME) begin
        w_reject = 1'b1;
      end else if (!w_frame_rw) begin
        w_reject = 1'b0;
      end else if (w_addr_ok) begin
        w_commit = 1'b1;
      end else begin
        w_reject = 1'b1;
      end
    end else begin
      w_commit = 1'b0;
      w_reject = 1'b0;
    end
  end

  // Datapath: bit counter, frame shifter, read shadow, register bank, outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_rw     <= 1'b0;
      r_shadow <= '0;
      r_regs   <= '0;
      r_strobe <= '0;
      r_err    <= 1'b0;
      r_cipo   <= 1'b0;
      r_oe     <= 1'b0;
    end else begin
      r_strobe <= '0;
      r_err    <= w_reject;
      r_oe     <= ~w_ncs;

      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_frame_addr == ADDR_W'(i)) begin
            r_regs[i]   <= w_frame_data;
            r_strobe[i] <= 1'b1;
          end
        end
      end

      if (r_state == S_IDLE) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_sclk_rise) begin
        r_cnt <= w_cnt_inc;
        if ((r_state == S_ADDR) || (r_state == S_DATA)) begin
          r_shift <= {r_shift[FRAME_LEN-2:0], w_copi};
        end
      end

      if (w_enter_data) begin
        r_rw     <= w_hdr[ADDR_W];
        r_shadow <= w_hdr[ADDR_W] ? '0 : w_rd_data;
      end else if ((r_state == S_DATA) && w_sclk_fall) begin
        r_shadow <= r_shadow << 1;
      end

      if ((r_state == S_DATA) && !r_rw) begin
        if (w_sclk_fall) begin
          r_cipo <= r_shadow[DATA_W-1];
        end
      end else begin
        r_cipo <= 1'b0;
      end
    end
  end

  assign regs_out  = r_regs;
  assign wr_strobe = r_strobe;
  assign frame_err = r_err;
  assign cipo      = r_cipo;
  assign cipo_oe   = r_oe;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed, table-driven bench for spi_reg_bank with default parameters.
module tb_spi_reg_bank;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        ncs;
  logic        copi;
  logic        cipo;
  logic        cipo_oe;
  logic [39:0] regs_out;
  logic [4:0]  wr_strobe;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  int str_cyc = 0;
  int err_cyc = 0;
  int hits [5] = '{0, 0, 0, 0, 0};

  spi_reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe != 5'b00000) str_cyc++;
    for (int i = 0; i < 5; i++) begin
      if (wr_strobe[i]) hits[i]++;
    end
    if (frame_err) err_cyc++;
  end

  typedef struct {
    logic [16:0] frame;
    int          nbits;
    int          gap;
    logic [39:0] exp_regs;
    logic [4:0]  exp_mask;
    int          exp_str;
    int          exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SPI bit: set copi, sample cipo just before the rising edge, pulse sclk.
  task automatic send_bit(input logic b, output logic s);
    copi = b;
    tick(HALF);
    s = cipo;
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
    tick(HALF);
  endtask

  task automatic xfer(input logic [16:0] frame, input int nbits, input int gap,
                      output logic [7:0] rd, output logic oe_mid);
    logic s;
    rd = 8'h00;
    ncs = 1'b0;
    tick(HALF);
    oe_mid = cipo_oe;
    for (int b = 0; b < nbits; b++) begin
      send_bit(frame[nbits-1-b], s);
      if (b >= 8 && b < 16) rd = {rd[6:0], s};
    end
    copi = 1'b0;
    ncs = 1'b1;
    tick(gap);
  endtask

  function automatic vec_t mkv(input logic [16:0] f, input int n, input int g,
                               input logic [39:0] r, input logic [4:0] m,
                               input int s, input int e, input logic [7:0] d);
    vec_t v;
    v.frame = f; v.nbits = n; v.gap = g; v.exp_regs = r;
    v.exp_mask = m; v.exp_str = s; v.exp_err = e; v.exp_rd = d;
    return v;
  endfunction

  initial begin
    logic [7:0] rd;
    logic       oe_mid;
    logic       s;
    logic [4:0] mask;
    int         str0;
    int         err0;
    int         snap [5];
    logic [16:0] tail;

    vecs[0]  = mkv(17'h084A5, 16, 8, 40'hA5_00_00_00_00, 5'b10000, 1, 0, 8'h00);
    vecs[1]  = mkv(17'h0813C, 16, 8, 40'hA5_00_00_3C_00, 5'b00010, 1, 0, 8'h00);
    vecs[2]  = mkv(17'h00100, 16, 8, 40'hA5_00_00_3C_00, 5'b00000, 0, 0, 8'h3C);
    vecs[3]  = mkv(17'h0823C, 16, 8, 40'hA5_00_3C_3C_00, 5'b00100, 1, 0, 8'h00);
    vecs[4]  = mkv(17'h00200, 16, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 0, 8'h3C);
    vecs[5]  = mkv(17'h00815, 12, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 1, 8'h00);
    vecs[6]  = mkv(17'h090FF, 16, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 1, 8'h00);
    vecs[7]  = mkv(17'h102EE, 17, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 1, 8'h00);
    vecs[8]  = mkv(17'h01000, 16, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 0, 8'h00);
    vecs[9]  = mkv(17'h00400, 16, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 0, 8'hA5);
    vecs[10] = mkv(17'h00000,  0, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 0, 8'h00);
    vecs[11] = mkv(17'h00000,  5, 8, 40'hA5_00_3C_3C_00, 5'b00000, 0, 1, 8'h00);
    vecs[12] = mkv(17'h08011, 16, 4, 40'hA5_00_3C_3C_11, 5'b00001, 1, 0, 8'h00);
    vecs[13] = mkv(17'h08122, 16, 8, 40'hA5_00_3C_22_11, 5'b00010, 1, 0, 8'h00);

    rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    tick(4);
    chk("rst_regs",   {24'h0, regs_out}, 64'h0);
    chk("rst_strobe", {59'h0, wr_strobe}, 64'h0);
    chk("rst_err",    {63'h0, frame_err}, 64'h0);
    chk("rst_cipo",   {63'h0, cipo}, 64'h0);
    chk("rst_oe",     {63'h0, cipo_oe}, 64'h0);
    rst = 1'b0;
    tick(8);

    for (int i = 0; i < 14; i++) begin
      str0 = str_cyc;
      err0 = err_cyc;
      for (int k = 0; k < 5; k++) snap[k] = hits[k];
      xfer(vecs[i].frame, vecs[i].nbits, vecs[i].gap, rd, oe_mid);
      for (int k = 0; k < 5; k++) mask[k] = (hits[k] != snap[k]);
      chk($sformatf("v%0d_regs", i),   {24'h0, regs_out}, {24'h0, vecs[i].exp_regs});
      chk($sformatf("v%0d_mask", i),   {59'h0, mask}, {59'h0, vecs[i].exp_mask});
      chk($sformatf("v%0d_strcyc", i), 64'(str_cyc - str0), 64'(vecs[i].exp_str));
      chk($sformatf("v%0d_errcyc", i), 64'(err_cyc - err0), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_rd", i),     {56'h0, rd}, {56'h0, vecs[i].exp_rd});
      chk($sformatf("v%0d_oe_mid", i), {63'h0, oe_mid}, 64'h1);
      chk($sformatf("v%0d_oe_end", i), {63'h0, cipo_oe}, 64'h0);
    end

    // Reset in the middle of a write: tail must be ignored, next frame commits.
    tail = 17'h0835A;
    str0 = str_cyc;
    err0 = err_cyc;
    ncs = 1'b0;
    tick(HALF);
    for (int b = 0; b < 9; b++) send_bit(tail[15-b], s);
    rst = 1'b1;
    tick(3);
    chk("mid_rst_regs",   {24'h0, regs_out}, 64'h0);
    chk("mid_rst_strobe", {59'h0, wr_strobe}, 64'h0);
    chk("mid_rst_err",    {63'h0, frame_err}, 64'h0);
    chk("mid_rst_cipo",   {63'h0, cipo}, 64'h0);
    chk("mid_rst_oe",     {63'h0, cipo_oe}, 64'h0);
    rst = 1'b0;
    for (int b = 9; b < 16; b++) send_bit(tail[15-b], s);
    copi = 1'b0;
    ncs = 1'b1;
    tick(8);
    chk("tail_regs",   {24'h0, regs_out}, 64'h0);
    chk("tail_strcyc", 64'(str_cyc - str0), 64'h0);
    chk("tail_errcyc", 64'(err_cyc - err0), 64'h0);

    str0 = str_cyc;
    err0 = err_cyc;
    for (int k = 0; k < 5; k++) snap[k] = hits[k];
    xfer(tail, 16, 8, rd, oe_mid);
    for (int k = 0; k < 5; k++) mask[k] = (hits[k] != snap[k]);
    chk("post_regs",   {24'h0, regs_out}, {24'h0, 40'h00_5A_00_00_00});
    chk("post_mask",   {59'h0, mask}, {59'h0, 5'b01000});
    chk("post_strcyc", 64'(str_cyc - str0), 64'h1);
    chk("post_errcyc", 64'(err_cyc - err0), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
